// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller driving the boundary-scan chain of the ripple-adder DFT wrapper.
// Optional feature macro: JTAG_TAP_IDCODE_EN adds the IDCODE instruction and 32-bit IDCODE register.
module jtag_tap_controller #(
   parameter int unsigned IR_WIDTH     = 4,
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   input  logic       TDI,
   input  logic       bsr_so,
   output logic       TDO,
   output logic       TDO_en,
   output logic       ShiftDR,
   output logic       ClockDR,
   output logic       UpdateDR,
   output logic       Mode,
   output logic [3:0] tap_state
);

   typedef enum logic [3:0] {
      EX2DR = 4'h0,
      EX1DR = 4'h1,
      SHDR  = 4'h2,
      PAUDR = 4'h3,
      SELIR = 4'h4,
      UPDDR = 4'h5,
      CAPDR = 4'h6,
      SELDR = 4'h7,
      EX2IR = 4'h8,
      EX1IR = 4'h9,
      SHIR  = 4'hA,
      PAUIR = 4'hB,
      RTI   = 4'hC,
      UPDIR = 4'hD,
      CAPIR = 4'hE,
      TLR   = 4'hF
   } tap_state_e;

   localparam logic [IR_WIDTH-1:0] OP_EXTEST  = '0;
   localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
   localparam int unsigned         ID_WIDTH   = 32;
   localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(2);
   localparam logic [IR_WIDTH-1:0] RESET_OP   = OP_IDCODE;
`else
   localparam logic [IR_WIDTH-1:0] RESET_OP   = '1;
`endif

   if (IR_WIDTH < 2 || !IDCODE_VALUE[0]) begin : g_param_check
      $error("jtag_tap_controller: IR_WIDTH must be >= 2 and IDCODE_VALUE[0] must be 1");
   end

   tap_state_e           state_q;
   tap_state_e           state_d;
   logic [IR_WIDTH-1:0]  ir_shift;
   logic [IR_WIDTH-1:0]  ir_latch;
   logic                 bypass_q;
   logic                 cdr_en;
   logic                 sel_chain;
   logic                 sel_bypass;
   logic                 dr_lsb;
`ifdef JTAG_TAP_IDCODE_EN
   logic                 sel_idcode;
   logic [ID_WIDTH-1:0]  id_shift;
`endif

   // TAP state register
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) state_q <= TLR;
      else      state_q <= state_d;
   end

   // TMS-driven next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:   state_d = TMS ? TLR   : RTI;
         RTI:   state_d = TMS ? SELDR : RTI;
         SELDR: state_d = TMS ? SELIR : CAPDR;
         CAPDR: state_d = TMS ? EX1DR : SHDR;
         SHDR:  state_d = TMS ? EX1DR : SHDR;
         EX1DR: state_d = TMS ? UPDDR : PAUDR;
         PAUDR: state_d = TMS ? EX2DR : PAUDR;
         EX2DR: state_d = TMS ? UPDDR : SHDR;
         UPDDR: state_d = TMS ? SELDR : RTI;
         SELIR: state_d = TMS ? TLR   : CAPIR;
         CAPIR: state_d = TMS ? EX1IR : SHIR;
         SHIR:  state_d = TMS ? EX1IR : SHIR;
         EX1IR: state_d = TMS ? UPDIR : PAUIR;
         PAUIR: state_d = TMS ? EX2IR : PAUIR;
         EX2IR: state_d = TMS ? UPDIR : SHIR;
         UPDIR: state_d = TMS ? SELDR : RTI;
         default: state_d = TLR;
      endcase
   end

   // Instruction decode and selected data-register serial output
   always_comb begin
      sel_chain = (ir_latch == OP_EXTEST) || (ir_latch == OP_SAMPLE);
`ifdef JTAG_TAP_IDCODE_EN
      sel_idcode = (ir_latch == OP_IDCODE);
      sel_bypass = !sel_chain && !sel_idcode;
`else
      sel_bypass = !sel_chain;
`endif
      dr_lsb = bypass_q;
      if (sel_chain) dr_lsb = bsr_so;
`ifdef JTAG_TAP_IDCODE_EN
      if (sel_idcode) dr_lsb = id_shift[0];
`endif
   end

   // Rising-edge capture/shift; cdr_en is settled while TCK is high so ClockDR never glitches
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_shift <= '0;
         bypass_q <= 1'b0;
         cdr_en   <= 1'b0;
      end else begin
         if (state_q == CAPIR)     ir_shift <= IR_CAPTURE;
         else if (state_q == SHIR) ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
         if (sel_bypass) begin
            if (state_q == CAPDR)     bypass_q <= 1'b0;
            else if (state_q == SHDR) bypass_q <= TDI;
         end
         cdr_en <= sel_chain && (state_d == CAPDR || state_d == SHDR);
      end
   end

`ifdef JTAG_TAP_IDCODE_EN
   // IDCODE register
   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) id_shift <= '0;
      else if (sel_idcode) begin
         if (state_q == CAPDR)     id_shift <= IDCODE_VALUE;
         else if (state_q == SHDR) id_shift <= {TDI, id_shift[ID_WIDTH-1:1]};
      end
   end
`endif

   // Falling-edge outputs and instruction latch
   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         ir_latch <= RESET_OP;
         Mode     <= 1'b0;
         TDO      <= 1'b0;
         TDO_en   <= 1'b0;
         ShiftDR  <= 1'b0;
         UpdateDR <= 1'b0;
      end else begin
         ShiftDR  <= sel_chain && (state_q == SHDR);
         UpdateDR <= sel_chain && (state_q == UPDDR);
         TDO_en   <= (state_q == SHIR) || (state_q == SHDR);
         if (state_q == SHIR)      TDO <= ir_shift[0];
         else if (state_q == SHDR) TDO <= dr_lsb;
         if (state_q == TLR) begin
            ir_latch <= RESET_OP;
            Mode     <= 1'b0;
         end else if (state_q == UPDIR) begin
            ir_latch <= ir_shift;
            Mode     <= (ir_shift == OP_EXTEST);
         end
      end
   end

   assign ClockDR   = ~TCK & cdr_en;
   assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: table-driven TAP model, 4-cell chain model, scan scenarios.
`timescale 1ns/1ps
module tb_jtag_tap_controller;

   localparam int unsigned IR_W    = 4;
   localparam int unsigned N_CELLS = 4;
   localparam logic [31:0] ID_VAL  = 32'h1000_0001;
`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IR_W-1:0] RESET_OP = 4'b0010;
`else
   localparam logic [IR_W-1:0] RESET_OP = 4'b1111;
`endif
   // 1149.1 transition table indexed by the tap_state code: next state for TMS=0 / TMS=1
   localparam logic [3:0] NXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                        4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
   localparam logic [3:0] NXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                        4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

   logic TCK = 1'b0;
   logic TRST, TMS, TDI, bsr_so;
   logic TDO, TDO_en, ShiftDR, ClockDR, UpdateDR, Mode;
   logic [3:0] tap_state;

   int checks = 0;
   int errors = 0;
   int cdr_pulses = 0;
   int upd_pulses = 0;
   int shift_rises = 0;
   logic [3:0]         model_state;
   logic [IR_W-1:0]    model_ir;
   logic [N_CELLS-1:0] chain;
   logic [N_CELLS-1:0] pins;

   jtag_tap_controller #(.IR_WIDTH(IR_W), .IDCODE_VALUE(ID_VAL)) dut (
      .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .bsr_so(bsr_so),
      .TDO(TDO), .TDO_en(TDO_en), .ShiftDR(ShiftDR), .ClockDR(ClockDR),
      .UpdateDR(UpdateDR), .Mode(Mode), .tap_state(tap_state)
   );

   always #5 TCK = ~TCK;

   // External boundary-scan cells: act on the trailing edge of each ClockDR pulse
   always @(negedge ClockDR) begin
      if (ShiftDR) chain <= {TDI, chain[N_CELLS-1:1]};
      else         chain <= pins;
   end
   assign bsr_so = chain[0];

   always @(posedge ClockDR)  cdr_pulses++;
   always @(posedge UpdateDR) upd_pulses++;
   always @(posedge ShiftDR)  shift_rises++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic rise(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      #1;
      model_state = tms ? NXT1[model_state] : NXT0[model_state];
   endtask

   task automatic fall();
      @(negedge TCK);
      #1;
   endtask

   task automatic step(input logic tms, input logic tdi);
      rise(tms, tdi);
      fall();
   endtask

   // From RTI: load op into IR and return to RTI; cap holds the bits seen on TDO
   task automatic ir_scan(input logic [IR_W-1:0] op, output logic [IR_W-1:0] cap);
      cap = '0;
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < int'(IR_W); i++) begin
         cap[i] = TDO;
         step(i == int'(IR_W) - 1, op[i]);
      end
      step(1, 0); step(0, 0);
      model_ir = op;
   endtask

   // From RTI: n-bit DR scan and return to RTI
   task automatic dr_scan(input int n, input logic [63:0] tin, output logic [63:0] tout);
      tout = '0;
      step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < n; i++) begin
         tout[i] = TDO;
         step(i == n - 1, tin[i]);
      end
      step(1, 0); step(0, 0);
   endtask

   // Expected TDO stream: captured register contents LSB-first, then TDI delayed by register length
   function automatic logic [63:0] expect_dr(input logic [IR_W-1:0] op, input int n,
                                             input logic [63:0] tin, input logic [N_CELLS-1:0] p);
      logic [63:0] capt;
      logic [63:0] r;
      int len;
      r = '0;
      if (op == 4'd0 || op == 4'd1) begin
         capt = 64'(p);
         len  = N_CELLS;
      end
`ifdef JTAG_TAP_IDCODE_EN
      else if (op == 4'd2) begin
         capt = 64'(ID_VAL);
         len  = 32;
      end
`endif
      else begin
         capt = '0;
         len  = 1;
      end
      for (int i = 0; i < n; i++) begin
         if (i < len) r[i] = capt[i];
         else         r[i] = tin[i - len];
      end
      return r;
   endfunction

   task automatic test_reset();
      TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; pins = '0;
      #1 TRST = 1'b1;
      #1;
      checks++;
      if ({tap_state, TDO, TDO_en, ShiftDR, UpdateDR, ClockDR, Mode} !== {4'hF, 6'b0}) begin
         errors++;
         $display("FAIL reset_outputs got %h_%b want f_000000", tap_state,
                  {TDO, TDO_en, ShiftDR, UpdateDR, ClockDR, Mode});
      end
      @(negedge TCK);
      #1 TRST = 1'b0;
      model_state = 4'hF;
      model_ir    = RESET_OP;
      step(1, 0); step(1, 0);
      checks++;
      if (tap_state !== 4'hF) begin
         errors++; $display("FAIL tlr_hold got %h want f", tap_state);
      end
      step(0, 0);
      checks++;
      if (tap_state !== 4'hC) begin
         errors++; $display("FAIL tlr_to_rti got %h want c", tap_state);
      end
   endtask

   task automatic test_state_walk();
      logic tms;
      for (int i = 0; i < 300; i++) begin
         tms = 1'($urandom);
         step(tms, 1'($urandom));
         checks++;
         if ({tap_state, TDO_en} !== {model_state, (model_state == 4'h2 || model_state == 4'hA)}) begin
            errors++;
            $display("FAIL walk step %0d got %h/%b want %h", i, tap_state, TDO_en, model_state);
         end
      end
      for (int i = 0; i < 5; i++) step(1, 0);
      checks++;
      if ({tap_state, Mode} !== {4'hF, 1'b0}) begin
         errors++; $display("FAIL walk_five_tms got %h mode %b want f mode 0", tap_state, Mode);
      end
      step(0, 0);
      model_ir = RESET_OP;
   endtask

   task automatic test_ir_extest();
      logic [IR_W-1:0] cap;
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      checks++;
      if ({tap_state, TDO_en} !== {4'hA, 1'b1}) begin
         errors++; $display("FAIL shir_entry got %h/%b want a/1", tap_state, TDO_en);
      end
      for (int i = 0; i < int'(IR_W); i++) begin
         cap[i] = TDO;
         step(i == int'(IR_W) - 1, 1'b0);
      end
      checks++;
      if (cap !== 4'b0001) begin
         errors++; $display("FAIL ir_capture got %b want 0001", cap);
      end
      checks++;
      if ({tap_state, TDO_en, Mode} !== {4'h9, 2'b00}) begin
         errors++; $display("FAIL ex1ir got %h/%b/%b want 9/0/0", tap_state, TDO_en, Mode);
      end
      rise(1, 0);
      checks++;
      if ({tap_state, Mode} !== {4'hD, 1'b0}) begin
         errors++; $display("FAIL mode_early got %h/%b want d/0", tap_state, Mode);
      end
      fall();
      checks++;
      if (Mode !== 1'b1) begin
         errors++; $display("FAIL mode_updir got %b want 1", Mode);
      end
      step(0, 0);
      model_ir = '0;
   endtask

   task automatic test_bypass();
      logic [IR_W-1:0] cap;
      logic [IR_W-1:0] op;
      logic [63:0] tin, tout, exp;
      int c0, u0, s0, n;
      ir_scan(4'b1111, cap);
      checks++;
      if ({cap, Mode} !== {4'b0001, 1'b0}) begin
         errors++; $display("FAIL bypass_ir got %b mode %b want 0001 mode 0", cap, Mode);
      end
      c0 = cdr_pulses; u0 = upd_pulses; s0 = shift_rises;
      dr_scan(4, 64'b1101, tout);
      checks++;
      if (tout[3:0] !== 4'b1010) begin
         errors++; $display("FAIL bypass_1011 got %b want 1010 (lsb first 0,1,0,1)", tout[3:0]);
      end
      checks++;
      if ({cdr_pulses - c0, upd_pulses - u0, shift_rises - s0} !== {32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL bypass_strobes got cdr %0d upd %0d shift %0d want 0", cdr_pulses - c0,
                  upd_pulses - u0, shift_rises - s0);
      end
      for (int k = 0; k < 4; k++) begin
`ifdef JTAG_TAP_IDCODE_EN
         op = IR_W'($urandom_range(3, 15));
`else
         op = IR_W'($urandom_range(2, 15));
`endif
         ir_scan(op, cap);
         n   = $urandom_range(1, 40);
         tin = {$urandom, $urandom};
         dr_scan(n, tin, tout);
         exp = expect_dr(op, n, tin, pins);
         checks++;
         if (tout !== exp) begin
            errors++; $display("FAIL bypass_rand op %b n %0d got %h want %h", op, n, tout, exp);
         end
      end
   endtask

   task automatic test_extest_chain();
      logic [IR_W-1:0] cap;
      logic [N_CELLS-1:0] tin, tout;
      logic [8:0] tms_seq;
      int c0, u0, s0;
      tms_seq = 9'b011000001;
      for (int r = 0; r < 2; r++) begin
         ir_scan(IR_W'(r), cap);
         checks++;
         if (Mode !== (r == 0)) begin
            errors++; $display("FAIL chain_mode op %0d got %b", r, Mode);
         end
         pins = N_CELLS'($urandom);
         tin  = N_CELLS'($urandom);
         tout = '0;
         c0 = cdr_pulses; u0 = upd_pulses; s0 = shift_rises;
         for (int i = 0; i < 9; i++) begin
            if (i >= 3 && i <= 6) begin
               tout[i-3] = TDO;
               step(tms_seq[i], tin[i-3]);
            end else begin
               step(tms_seq[i], 1'b0);
            end
            checks++;
            if ({ShiftDR, UpdateDR} !== {model_state == 4'h2, model_state == 4'h5}) begin
               errors++;
               $display("FAIL chain_strobe state %h got sh %b up %b", model_state, ShiftDR, UpdateDR);
            end
         end
         checks++;
         if (tout !== pins) begin
            errors++; $display("FAIL chain_tdo got %b want %b", tout, pins);
         end
         checks++;
         if (chain !== tin) begin
            errors++; $display("FAIL chain_load got %b want %b", chain, tin);
         end
         checks++;
         if ({cdr_pulses - c0, upd_pulses - u0, shift_rises - s0} !== {32'd5, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL chain_pulses got cdr %0d upd %0d shift %0d want 5 1 1", cdr_pulses - c0,
                     upd_pulses - u0, shift_rises - s0);
         end
      end
   endtask

   task automatic test_pause();
      logic [IR_W-1:0] cap;
      logic [N_CELLS-1:0] tin, tout;
      int c0, cp;
      ir_scan(4'b0000, cap);
      pins = N_CELLS'($urandom);
      tin  = N_CELLS'($urandom);
      c0 = cdr_pulses;
      step(1, 0); step(0, 0); step(0, 0);
      tout[0] = TDO; step(0, tin[0]);
      tout[1] = TDO; step(1, tin[1]);
      cp = cdr_pulses;
      step(0, 0); step(0, 0); step(0, 0);
      checks++;
      if ({tap_state, TDO_en, ClockDR} !== {4'h3, 2'b00}) begin
         errors++; $display("FAIL pause_state got %h/%b/%b want 3/0/0", tap_state, TDO_en, ClockDR);
      end
      step(1, 0);
      checks++;
      if (cdr_pulses - cp !== 0) begin
         errors++; $display("FAIL pause_clockdr got %0d want 0", cdr_pulses - cp);
      end
      step(0, 0);
      tout[2] = TDO; step(0, tin[2]);
      tout[3] = TDO; step(1, tin[3]);
      step(1, 0); step(0, 0);
      checks++;
      if ({tout, chain} !== {pins, tin}) begin
         errors++; $display("FAIL pause_data got %b/%b want %b/%b", tout, chain, pins, tin);
      end
      checks++;
      if (cdr_pulses - c0 !== 5) begin
         errors++; $display("FAIL pause_total got %0d want 5", cdr_pulses - c0);
      end
   endtask

   task automatic test_trst_mid_shift();
      logic [IR_W-1:0] cap;
      logic [63:0] tin, tout, exp;
      int c0, n;
      ir_scan(4'b0000, cap);
      checks++;
      if (Mode !== 1'b1) begin
         errors++; $display("FAIL trst_pre_mode got %b want 1", Mode);
      end
      step(1, 0); step(0, 0); step(0, 0);
      rise(0, 1);
      c0 = cdr_pulses;
      TRST = 1'b1;
      #1;
      checks++;
      if ({tap_state, Mode, ShiftDR, UpdateDR, TDO_en, ClockDR} !== {4'hF, 5'b0}) begin
         errors++;
         $display("FAIL trst_async got %h_%b want f_00000", tap_state,
                  {Mode, ShiftDR, UpdateDR, TDO_en, ClockDR});
      end
      fall();
      checks++;
      if ({cdr_pulses - c0, 31'(ClockDR)} !== {32'd0, 31'd0}) begin
         errors++; $display("FAIL trst_partial_pulse got %0d pulses want 0", cdr_pulses - c0);
      end
      TRST = 1'b0;
      model_state = 4'hF;
      model_ir    = RESET_OP;
      step(0, 0);
      n   = $urandom_range(8, 40);
      tin = {$urandom, $urandom};
      dr_scan(n, tin, tout);
      exp = expect_dr(model_ir, n, tin, pins);
      checks++;
      if (tout !== exp) begin
         errors++; $display("FAIL trst_ir_reset got %h want %h", tout, exp);
      end
      step(1, 0); step(0, 0); step(0, 0);
      checks++;
      if (tap_state !== 4'h2) begin
         errors++; $display("FAIL shdr_reach got %h want 2", tap_state);
      end
      for (int i = 0; i < 5; i++) step(1, 1'($urandom));
      checks++;
      if (tap_state !== 4'hF) begin
         errors++; $display("FAIL five_tms_from_shdr got %h want f", tap_state);
      end
      step(0, 0);
   endtask

   task automatic test_reset_instruction();
      logic [IR_W-1:0] cap;
      logic [63:0] tin, tout, exp;
      TRST = 1'b1;
      #2 TRST = 1'b0;
      model_state = 4'hF;
      model_ir    = RESET_OP;
      step(0, 0);
      tin = {$urandom, $urandom};
      dr_scan(40, tin, tout);
      exp = expect_dr(RESET_OP, 40, tin, pins);
      checks++;
      if (tout !== exp) begin
         errors++; $display("FAIL reset_instr_scan got %h want %h", tout, exp);
      end
`ifdef JTAG_TAP_IDCODE_EN
      checks++;
      if (tout[31:0] !== ID_VAL) begin
         errors++; $display("FAIL idcode got %h want %h", tout[31:0], ID_VAL);
      end
`endif
      ir_scan(4'b0010, cap);
      tin = {$urandom, $urandom};
      dr_scan(36, tin, tout);
      exp = expect_dr(4'b0010, 36, tin, pins);
      checks++;
      if (tout !== exp) begin
         errors++; $display("FAIL op0010_scan got %h want %h", tout, exp);
      end
   endtask

   initial begin
      model_state = 4'hF;
      model_ir    = RESET_OP;
      test_reset();
      test_state_walk();
      test_ir_extest();
      test_bypass();
      test_extest_chain();
      test_pause();
      test_trst_mid_shift();
      test_reset_instruction();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
